datapath_ctrl: RTL and testbench

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/dpc_pkg.sv | 42 ++++
 rtl/dpc_decode.sv | 18 +
 rtl/vDFF.sv | 11 +
 rtl/datapath_ctrl.sv | 85 ++++++++
 tb/tb_datapath_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/dpc_pkg.sv
// dpc_pkg: state encodings, instruction constants and select codes for datapath_ctrl (ERR state exists only under DPC_ILLEGAL_TRAP_EN)
package dpc_pkg;
    typedef enum logic [2:0] {
        S_WAIT   = 3'b000,
        S_DECODE = 3'b001,
        S_GETA   = 3'b010,
        S_GETB   = 3'b011,
        S_ALU    = 3'b100,
        S_WRREG  = 3'b101,
        S_WRIMM  = 3'b110
`ifdef DPC_ILLEGAL_TRAP_EN
        , S_ERR  = 3'b111
`endif
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    typedef struct packed {
        logic imm;
        logic regmov;
        logic alu2;
        logic mvn;
        logic cmp;
        logic illegal;
    } dec_t;
endpackage

// File: rtl/dpc_decode.sv
// dpc_decode: combinational classification of {opcode, op} into instruction classes
module dpc_decode
    import dpc_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output dec_t       dec
);
    logic mov, alu;
    assign mov         = (opcode == OPC_MOV);
    assign alu         = (opcode == OPC_ALU);
    assign dec.imm     = mov && (op == OP_MOV_IMM);
    assign dec.regmov  = mov && (op == OP_MOV_REG);
    assign dec.alu2    = alu && (op == OP_ADD || op == OP_AND);
    assign dec.mvn     = alu && (op == OP_MVN);
    assign dec.cmp     = alu && (op == OP_CMP);
    assign dec.illegal = !(dec.imm || dec.regmov || dec.alu2 || dec.mvn || dec.cmp);
endmodule

// File: rtl/vDFF.sv
// vDFF: plain n-bit rising-edge register, shared across the codebase
module vDFF #(
    parameter int n = 1
) (
    input  logic         clk,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);
    // capture d every rising edge; any reset is muxed in by the caller
    always_ff @(posedge clk) q <= d;
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore controller sequencing register reads, ALU and write-back; DPC_ILLEGAL_TRAP_EN adds a sticky ERR trap
module datapath_ctrl
    import dpc_pkg::*;
#(
    parameter int ST_W = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       asel,
    output logic       bsel,
    output logic       err
);
    logic [ST_W-1:0] st_q, st_d;
    state_t          st, nx;
    dec_t            dec;
    logic            k_cmp, k_zero_a;

    dpc_decode u_dec (.opcode(opcode), .op(op), .dec(dec));

    assign st   = state_t'(st_q);
    assign st_d = reset_n ? ST_W'(nx) : ST_W'(S_WAIT);

    vDFF #(.n(ST_W)) u_state (.clk(clk), .d(st_d), .q(st_q));

`ifdef DPC_ILLEGAL_TRAP_EN
    localparam state_t S_TRAP = S_ERR;
    assign err = (st == S_ERR);
`else
    localparam state_t S_TRAP = S_WAIT;
    assign err = 1'b0;
`endif

    // latch the ALU flavour at DECODE so ALU-state outputs come from registers, not live inputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k_cmp    <= 1'b0;
            k_zero_a <= 1'b0;
        end else if (st == S_DECODE) begin
            k_cmp    <= dec.cmp;
            k_zero_a <= dec.regmov || dec.mvn;
        end
    end

    // next-state sequencing
    always_comb begin
        nx = S_WAIT;
        case (st)
            S_WAIT:   nx = s ? S_DECODE : S_WAIT;
            S_DECODE: nx = dec.illegal ? S_TRAP :
                           dec.imm ? S_WRIMM :
                           (dec.alu2 || dec.cmp) ? S_GETA : S_GETB;
            S_GETA:   nx = S_GETB;
            S_GETB:   nx = S_ALU;
            S_ALU:    nx = k_cmp ? S_WAIT : S_WRREG;
`ifdef DPC_ILLEGAL_TRAP_EN
            S_ERR:    nx = S_ERR;
`endif
            default:  nx = S_WAIT;
        endcase
    end

    assign w     = (st == S_WAIT);
    assign loada = (st == S_GETA);
    assign loadb = (st == S_GETB);
    assign loadc = (st == S_ALU) && !k_cmp;
    assign loads = (st == S_ALU) && k_cmp;
    assign asel  = (st == S_ALU) && k_zero_a;
    assign bsel  = 1'b0;
    assign write = (st == S_WRREG) || (st == S_WRIMM);
    assign vsel  = (st == S_WRIMM) ? VSEL_IMM : VSEL_C;
    assign nsel  = (st == S_GETA || st == S_WRIMM) ? NSEL_RN :
                   (st == S_GETB) ? NSEL_RM :
                   (st == S_WRREG) ? NSEL_RD : NSEL_NONE;
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: scoreboard bench for datapath_ctrl; honours DPC_ILLEGAL_TRAP_EN for illegal-instruction expectations
module tb_datapath_ctrl;
    typedef logic [13:0] vec_t;
    typedef vec_t vq_t[$];

    logic       clk = 1'b0;
    logic       reset_n, s;
    logic [2:0] opcode, nsel;
    logic [1:0] op, vsel;
    logic       w, loada, loadb, loadc, loads, write, asel, bsel, err;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    vq_t  exp_q;
    vq_t  plan;
    logic trapped = 1'b0;

    datapath_ctrl #(.ST_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .write(write), .asel(asel),
        .bsel(bsel), .err(err)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic vw, verr, input logic [2:0] vn, input logic [1:0] vv,
                               input logic la, lb, lc, ls, wr, as);
        return {vw, verr, vn, vv, la, lb, lc, ls, wr, as, 1'b0};
    endfunction

    function automatic vec_t idle_v();
        return v(1, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t err_v();
        return v(0, 1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction

    // outputs after each edge of one instruction, ending with the return to idle
    function automatic vq_t build(input logic [2:0] oc, input logic [1:0] o);
        vq_t  q;
        logic mov = (oc == 3'b110);
        logic alu = (oc == 3'b101);
        vec_t dec_v  = v(0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
        vec_t geta_v = v(0, 0, 3'b001, 2'b00, 1, 0, 0, 0, 0, 0);
        vec_t getb_v = v(0, 0, 3'b100, 2'b00, 0, 1, 0, 0, 0, 0);
        vec_t wrrg_v = v(0, 0, 3'b010, 2'b00, 0, 0, 0, 0, 1, 0);
        q = {};
        q.push_back(dec_v);
        if (mov && o == 2'b10) begin
            q.push_back(v(0, 0, 3'b001, 2'b10, 0, 0, 0, 0, 1, 0));
            q.push_back(idle_v());
        end else if ((mov && o == 2'b00) || (alu && o == 2'b11)) begin
            q.push_back(getb_v);
            q.push_back(v(0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 1));
            q.push_back(wrrg_v);
            q.push_back(idle_v());
        end else if (alu) begin
            q.push_back(geta_v);
            q.push_back(getb_v);
            if (o == 2'b01) begin
                q.push_back(v(0, 0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0));
            end else begin
                q.push_back(v(0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0));
                q.push_back(wrrg_v);
            end
            q.push_back(idle_v());
        end else begin
`ifdef DPC_ILLEGAL_TRAP_EN
            q.push_back(err_v());
`else
            q.push_back(idle_v());
`endif
        end
        return q;
    endfunction

    // advance one edge: update the reference model from the inputs just sampled and queue the expectation
    task automatic step();
        vec_t e;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            plan    = {};
            trapped = 1'b0;
            e       = idle_v();
        end else if (trapped) begin
            e = err_v();
        end else if (plan.size() == 0) begin
            if (s) begin
                plan = build(opcode, op);
                e    = plan.pop_front();
            end else begin
                e = idle_v();
            end
        end else begin
            e = plan.pop_front();
            if (plan.size() == 0 && e == err_v()) trapped = 1'b1;
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic drive(input logic rn, input logic sv, input logic [2:0] oc, input logic [1:0] o, input int n);
        reset_n = rn;
        s       = sv;
        opcode  = oc;
        op      = o;
        for (int i = 0; i < n; i++) step();
    endtask

    // monitor: compare every presented output vector against the scoreboard head
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e, got;
            e   = exp_q.pop_front();
            got = {w, err, nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel};
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL outputs cyc=%0d got w/err/nsel/vsel/la/lb/lc/ls/wr/as/bs=%b required %b", cyc, got, e);
            end
        end
    end

    initial begin
        logic [2:0] oc;
        logic [1:0] o;
        int         pick;
        drive(0, 1, 3'b110, 2'b10, 2);
        drive(1, 1, 3'b110, 2'b10, 1);
        drive(1, 0, 3'b110, 2'b10, 3);
        drive(1, 1, 3'b101, 2'b00, 1);
        drive(1, 0, 3'b101, 2'b00, 6);
        drive(1, 1, 3'b101, 2'b01, 1);
        drive(1, 0, 3'b101, 2'b01, 5);
        drive(1, 1, 3'b101, 2'b00, 1);
        drive(1, 0, 3'b101, 2'b00, 1);
        drive(0, 0, 3'b101, 2'b00, 1);
        drive(1, 0, 3'b101, 2'b00, 3);
        drive(1, 1, 3'b101, 2'b11, 11);
        drive(1, 0, 3'b101, 2'b11, 5);
        drive(1, 1, 3'b110, 2'b00, 1);
        drive(1, 0, 3'b110, 2'b00, 5);
        drive(1, 1, 3'b111, 2'b00, 1);
        drive(1, 0, 3'b111, 2'b00, 4);
        drive(0, 0, 3'b111, 2'b00, 1);
        drive(1, 0, 3'b110, 2'b10, 2);
        oc = 3'b110;
        o  = 2'b10;
        for (int i = 0; i < 4000; i++) begin
            if (plan.size() == 0 && !trapped) begin
                pick = $urandom_range(0, 7);
                case (pick)
                    0: begin oc = 3'b110; o = 2'b10; end
                    1: begin oc = 3'b110; o = 2'b00; end
                    2: begin oc = 3'b101; o = 2'b00; end
                    3: begin oc = 3'b101; o = 2'b01; end
                    4: begin oc = 3'b101; o = 2'b10; end
                    5: begin oc = 3'b101; o = 2'b11; end
                    default: begin oc = 3'($urandom); o = 2'($urandom); end
                endcase
            end
            drive(logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 2) != 0), oc, o, 1);
        end
        drive(1, 0, oc, o, 2);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
